// File: rtl/gpr_sb_if.sv
// Register-file port bundle: read ports, two write ports, scoreboard set and status.
// The master side is the decode/writeback pipeline; the slave side is the register file.
interface gpr_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wa_we_;
   logic [ADDR_W-1:0]        wa_addr;
   logic [DATA_W-1:0]        wa_data;
   logic                     wb_we_;
   logic [ADDR_W-1:0]        wb_addr;
   logic [DATA_W-1:0]        wb_data;
   logic                     sb_set_;
   logic [ADDR_W-1:0]        sb_addr;
   logic [ADDR_W:0]          busy_cnt;
   logic [1:0]               err;

   modport master (
      output rd_addr, wa_we_, wa_addr, wa_data, wb_we_, wb_addr, wb_data, sb_set_, sb_addr,
      input  rd_data, rd_busy, busy_cnt, err
   );

   modport slave (
      input  rd_addr, wa_we_, wa_addr, wa_data, wb_we_, wb_addr, wb_data, sb_set_, sb_addr,
      output rd_data, rd_busy, busy_cnt, err
   );
endinterface

// File: rtl/gpr_sb_file.sv
// General-purpose register file with two write ports, write-through bypass on every read
// port and a per-register pending-load scoreboard used by decode for load-use stalls.
module gpr_sb_file #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_RD  = 2,
   parameter int ZERO_R0 = 1
) (
   input logic    clk,
   input logic    reset_,
   gpr_sb_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam bit ZR    = (ZERO_R0 != 0);

   logic [DATA_W-1:0]        regs [DEPTH];
   logic [DEPTH-1:0]         busy;
   logic [DEPTH-1:0]         busy_nxt;
   logic [ADDR_W:0]          busy_cnt_q;
   logic [ADDR_W:0]          cnt_nxt;
   logic [1:0]               err_q;
   logic [1:0]               err_new;
   logic                     wa_act;
   logic                     wb_act;
   logic                     wb_clr;
   logic                     sb_act;
   logic [ADDR_W-1:0]        rd_a;
   logic                     hit_b;
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;

   // With ZR set, register 0 is hard-wired: writes and load marks to it vanish here.
   assign wa_act = !bus.wa_we_  && !(ZR && bus.wa_addr == '0);
   assign wb_act = !bus.wb_we_  && !(ZR && bus.wb_addr == '0);
   assign sb_act = !bus.sb_set_ && !(ZR && bus.sb_addr == '0);
   assign wb_clr = !bus.wb_we_;

   always_comb begin
      busy_nxt = busy;
      if (wb_clr) busy_nxt[bus.wb_addr] = 1'b0;
      // A new load issued to the register being returned takes priority over the clear.
      if (sb_act) busy_nxt[bus.sb_addr] = 1'b1;
      cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
      err_new[0] = wa_act && wb_act && (bus.wa_addr == bus.wb_addr);
      err_new[1] = sb_act && busy[bus.sb_addr] && !(wb_clr && bus.wb_addr == bus.sb_addr);
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy       <= '0;
         busy_cnt_q <= '0;
         err_q      <= 2'b00;
      end else begin
         if (wa_act) regs[bus.wa_addr] <= bus.wa_data;
         if (wb_act) regs[bus.wb_addr] <= bus.wb_data;
         busy       <= busy_nxt;
         busy_cnt_q <= cnt_nxt;
         err_q      <= err_q | err_new;
      end
   end

   // Read priority: port B bypass, then port A bypass, then stored contents.
   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      rd_a      = '0;
      hit_b     = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_a  = bus.rd_addr[i*ADDR_W +: ADDR_W];
         hit_b = !bus.wb_we_ && (bus.wb_addr == rd_a);
         if (ZR && rd_a == '0)
            rd_data_c[i*DATA_W +: DATA_W] = '0;
         else if (hit_b)
            rd_data_c[i*DATA_W +: DATA_W] = bus.wb_data;
         else if (!bus.wa_we_ && bus.wa_addr == rd_a)
            rd_data_c[i*DATA_W +: DATA_W] = bus.wa_data;
         else
            rd_data_c[i*DATA_W +: DATA_W] = regs[rd_a];
         rd_busy_c[i] = busy[rd_a] & ~hit_b;
      end
   end

   assign bus.rd_data  = rd_data_c;
   assign bus.rd_busy  = rd_busy_c;
   assign bus.busy_cnt = busy_cnt_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_gpr_sb_file.sv
// Scoreboard bench for gpr_sb_file: the driver pushes model-predicted outputs per cycle and
// an independent negedge monitor pops and compares them against the DUT.
module tb_gpr_sb_file;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int NUM_RD  = 2;
   localparam int ZERO_R0 = 1;
   localparam int DEPTH   = 1 << ADDR_W;

   typedef struct {
      logic [ADDR_W-1:0] rd0, rd1;
      bit                wa_en, wb_en, sb_en;
      logic [ADDR_W-1:0] wa_addr, wb_addr, sb_addr;
      logic [DATA_W-1:0] wa_data, wb_data;
   } stim_t;

   typedef struct {
      logic [NUM_RD*DATA_W-1:0] data;
      logic [NUM_RD-1:0]        busy;
      logic [ADDR_W:0]          cnt;
      logic [1:0]               err;
      string                    tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset_ = 1'b0;
   always #5 clk = ~clk;

   gpr_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

   gpr_sb_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_R0(ZERO_R0)) dut (
      .clk   (clk),
      .reset_(reset_),
      .bus   (bus)
   );

   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_busy [DEPTH];
   logic [1:0]        m_err;
   exp_t              scb [$];
   exp_t              mon_e;
   int                total = 0;
   int                bad = 0;
   int                pushed = 0;
   int                popped = 0;

   function automatic stim_t idle(input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1);
      stim_t s;
      s.rd0 = r0; s.rd1 = r1;
      s.wa_en = 0; s.wb_en = 0; s.sb_en = 0;
      s.wa_addr = '0; s.wb_addr = '0; s.sb_addr = '0;
      s.wa_data = '0; s.wb_data = '0;
      return s;
   endfunction

   function automatic bit is_zero_reg(input logic [ADDR_W-1:0] a);
      return (ZERO_R0 != 0) && (a == 0);
   endfunction

   function automatic logic [DATA_W-1:0] model_read(input stim_t s, input logic [ADDR_W-1:0] a);
      if (is_zero_reg(a)) return '0;
      if (s.wb_en && s.wb_addr == a) return s.wb_data;
      if (s.wa_en && s.wa_addr == a) return s.wa_data;
      return m_mem[a];
   endfunction

   function automatic bit model_busy(input stim_t s, input logic [ADDR_W-1:0] a);
      return m_busy[a] && !(s.wb_en && s.wb_addr == a);
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 0;
      end
      m_err = 2'b00;
   endtask

   task automatic drive_bus(input stim_t s);
      bus.rd_addr = {s.rd1, s.rd0};
      bus.wa_we_  = !s.wa_en; bus.wa_addr = s.wa_addr; bus.wa_data = s.wa_data;
      bus.wb_we_  = !s.wb_en; bus.wb_addr = s.wb_addr; bus.wb_data = s.wb_data;
      bus.sb_set_ = !s.sb_en; bus.sb_addr = s.sb_addr;
   endtask

   task automatic push_expect(input stim_t s, input string tag);
      exp_t e;
      e.data = {model_read(s, s.rd1), model_read(s, s.rd0)};
      e.busy = {model_busy(s, s.rd1), model_busy(s, s.rd0)};
      e.cnt  = (ADDR_W+1)'(model_count());
      e.err  = m_err;
      e.tag  = tag;
      scb.push_back(e);
      pushed++;
   endtask

   // Called one time unit after a rising edge; returns one time unit after the next one.
   task automatic applyStimulus(input stim_t s, input string tag);
      bit wa_ok, wb_ok, sb_ok;
      drive_bus(s);
      push_expect(s, tag);
      @(posedge clk);
      wa_ok = s.wa_en && !is_zero_reg(s.wa_addr);
      wb_ok = s.wb_en && !is_zero_reg(s.wb_addr);
      sb_ok = s.sb_en && !is_zero_reg(s.sb_addr);
      if (wa_ok && wb_ok && s.wa_addr == s.wb_addr) m_err[0] = 1'b1;
      if (sb_ok && m_busy[s.sb_addr] && !(s.wb_en && s.wb_addr == s.sb_addr)) m_err[1] = 1'b1;
      if (wa_ok) m_mem[s.wa_addr] = s.wa_data;
      if (wb_ok) m_mem[s.wb_addr] = s.wb_data;
      if (s.wb_en) m_busy[s.wb_addr] = 0;
      if (sb_ok) m_busy[s.sb_addr] = 1;
      #1;
   endtask

   task automatic checkOutput(input exp_t e);
      total++;
      if (bus.rd_data !== e.data) begin
         bad++;
         $display("[TB] FAIL %s rd_data got=%h want=%h", e.tag, bus.rd_data, e.data);
      end
      total++;
      if (bus.rd_busy !== e.busy) begin
         bad++;
         $display("[TB] FAIL %s rd_busy got=%b want=%b", e.tag, bus.rd_busy, e.busy);
      end
      total++;
      if (bus.busy_cnt !== e.cnt) begin
         bad++;
         $display("[TB] FAIL %s busy_cnt got=%0d want=%0d", e.tag, bus.busy_cnt, e.cnt);
      end
      total++;
      if (bus.err !== e.err) begin
         bad++;
         $display("[TB] FAIL %s err got=%b want=%b", e.tag, bus.err, e.err);
      end
   endtask

   always @(negedge clk) begin
      if (scb.size() > 0) begin
         mon_e = scb.pop_front();
         popped++;
         checkOutput(mon_e);
      end
   end

   initial begin
      stim_t s;
      model_reset();
      drive_bus(idle('0, '0));
      repeat (2) @(posedge clk);
      #1 reset_ = 1'b1;

      for (int a = 0; a < DEPTH; a++)
         applyStimulus(idle(ADDR_W'(a), ADDR_W'(DEPTH-1-a)), "reset_read");

      s = idle(5, 5); s.wa_en = 1; s.wa_addr = 5; s.wa_data = 32'h1234_5678;
      applyStimulus(s, "a_bypass_r5");
      applyStimulus(idle(5, 4), "a_stored_r5");

      s = idle(0, 0); s.wa_en = 1; s.wa_addr = 0; s.wa_data = 32'hFFFF_FFFF;
      s.sb_en = 1; s.sb_addr = 0;
      applyStimulus(s, "r0_write_set");
      applyStimulus(idle(0, 0), "r0_after");

      s = idle(7, 7); s.wa_en = 1; s.wa_addr = 7; s.wa_data = 32'hAAAA_AAAA;
      s.wb_en = 1; s.wb_addr = 7; s.wb_data = 32'h5555_5555;
      applyStimulus(s, "ab_collide_r7");
      applyStimulus(idle(7, 5), "ab_stored_r7");

      s = idle(3, 3); s.sb_en = 1; s.sb_addr = 3;
      applyStimulus(s, "sb_set_r3");
      applyStimulus(idle(3, 0), "r3_busy");
      s = idle(3, 3); s.wb_en = 1; s.wb_addr = 3; s.wb_data = 32'h42;
      applyStimulus(s, "r3_return");
      applyStimulus(idle(3, 7), "r3_cleared");

      s = idle(9, 9); s.sb_en = 1; s.sb_addr = 9;
      applyStimulus(s, "sb_r9_first");
      applyStimulus(s, "sb_r9_second");
      applyStimulus(idle(9, 3), "r9_double");

      // Asynchronous reset taken mid-cycle, away from any clock edge.
      drive_bus(idle(9, 5));
      reset_ = 1'b0;
      #1;
      model_reset();
      push_expect(idle(9, 5), "mid_reset");
      @(posedge clk);
      #1 reset_ = 1'b1;
      applyStimulus(idle(7, 3), "post_reset");

      for (int n = 0; n < 400; n++) begin
         s.rd0     = ADDR_W'($urandom_range(0, 7));
         s.rd1     = ADDR_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 7));
         s.wa_en   = ($urandom_range(0, 1) == 1);
         s.wb_en   = ($urandom_range(0, 2) == 0);
         s.sb_en   = ($urandom_range(0, 2) == 0);
         s.wa_addr = ADDR_W'($urandom_range(0, 7));
         s.wb_addr = ADDR_W'($urandom_range(0, 7));
         s.sb_addr = ADDR_W'($urandom_range(0, 7));
         s.wa_data = $urandom;
         s.wb_data = $urandom;
         applyStimulus(s, "random");
      end

      drive_bus(idle('0, '0));
      repeat (2) @(negedge clk);
      total++;
      if (scb.size() != 0 || popped != pushed) begin
         bad++;
         $display("[TB] FAIL drain left=%0d popped=%0d pushed=%0d", scb.size(), popped, pushed);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
